ising_core_ctrl_regs: RTL and testbench
=======================================

// Module: ising_core_ctrl_regs
// PURPOSE
//  Register-interface front end of one Ising core: decodes the external reg bus slice reg_ext_req[i] from Cheshire.
//  Sequences one anneal job (load, then N iterations) and tracks iteration count and best energy.
//  Raises a level interrupt on completion; sits between the SoC register demux and the core datapath.
// PARAMETERS
//  AddrWidth    8   reg address bits (byte address, word-aligned)
//  DataWidth    32  reg data width; wstrb = DataWidth/8
//  IterWidth    16  width of NUM_ITER / ITER_CNT
//  EnergyWidth  24  signed energy width from core
// PORTS
//  clk_i              in   1            core clock
//  rst_i              in   1            reset
//  reg_valid_i        in   1            reg request valid
//  reg_write_i        in   1            1=write, 0=read
//  reg_addr_i         in   AddrWidth    byte address
//  reg_wdata_i        in   DataWidth    write data
//  reg_wstrb_i        in   DataWidth/8  byte strobes
//  reg_ready_o        out  1            response valid / request accepted
//  reg_rdata_o        out  DataWidth    read data
//  reg_error_o        out  1            access error
//  core_load_o        out  1            request core to load J/h from L1 (level until ack)
//  core_load_ack_i    in   1            load complete (1-cycle pulse)
//  core_iter_start_o  out  1            start one iteration (1-cycle pulse)
//  core_iter_done_i   in   1            iteration finished (1-cycle pulse)
//  core_energy_i      in   EnergyWidth  signed energy, valid with core_iter_done_i
//  core_abort_o       out  1            abort pulse to core
//  irq_o              out  1            level interrupt
// BEHAVIOUR
//  Reset: one clock clk_i; reset rst_i is synchronous, active-high. All outputs 0; FSM=IDLE; all regs 0 except BEST_E = max positive.
//  Reg bus: reg_ready_o = reg_valid_i (zero-wait); rdata/error combinational; side effects at clock edge.
//  Map: 0x00 CTRL  W: b0 START, b1 ABORT (self-clearing, read 0), b2 IRQ_EN (R/W).
//       0x04 STATUS R: b0 BUSY, b1 DONE, b2 ABORTED; W1C on b1/b2.
//       0x08 NUM_ITER R/W [IterWidth-1:0], byte strobes honoured.
//       0x0C ITER_CNT RO; 0x10 BEST_E RO (sign-extended); 0x14 PERF_CYC RO (see CONFIGURATION).
//  Errors (write ignored, error=1): unmapped addr, write to RO, START or NUM_ITER write while BUSY. Unmapped read returns rdata=0.
//  CTRL bits act only if wstrb[0]=1.
//  FSM IDLE->LOAD on START with NUM_ITER!=0: clear ITER_CNT, DONE, ABORTED; BEST_E=max positive.
//  START with NUM_ITER==0: DONE set next cycle, no core activity.
//  LOAD: core_load_o=1 until core_load_ack_i, then ISSUE.
//  ISSUE: core_iter_start_o=1 for exactly one cycle, then WAIT.
//  WAIT: on core_iter_done_i: ITER_CNT++ and BEST_E=min(BEST_E, energy) (signed).
//    If the new ITER_CNT==NUM_ITER go to FIN, else go to ISSUE. Iteration pitch is >=2 cycles.
//  FIN: set DONE, go to IDLE; BUSY=0 in IDLE only.
//  ABORT while BUSY: core_abort_o pulses 1 cycle, FSM->IDLE, ABORTED set; ITER_CNT/BEST_E frozen.
//  ABORT in IDLE: no effect, no error.
//  Simultaneous ABORT and core_iter_done_i: abort wins; the iteration is not counted.
//  Simultaneous load_ack and ABORT: abort wins.
//  ITER_CNT saturates at all-ones (cannot exceed NUM_ITER anyway).
//  irq_o = IRQ_EN & (DONE | ABORTED), registered (1-cycle latency after flag set).
//  Reset mid-job: immediate return to IDLE; no abort pulse emitted.
// CONFIGURATION
//  ISING_CORE_CTRL_PERF_EN defined: 32-bit PERF_CYC counts cycles with BUSY=1.
//    It clears on accepted START and saturates at 0xFFFF_FFFF.
//  Not defined: no counter; 0x14 reads 0 with error=0.
// STRUCTURE
//  Shared package ising_logic_pkg: register offsets, CTRL/STATUS bit indices, FSM enum ctrl_state_e.
//  ising_logic_pkg also holds a reg-map struct typedef.
//  Sub-module ising_energy_min_tracker: signed min register with clear and update strobe, param EnergyWidth.
// TESTING
//  NUM_ITER=3, START; each done 4 cycles after start, energies -5,-9,-7:
//    ITER_CNT=3, BEST_E=-9, DONE=1, exactly 3 start pulses.
//  NUM_ITER=0, START: DONE=1 next cycle, core_load_o never asserted, BUSY never 1.
//  Busy job: write NUM_ITER=8 and START -> reg_error_o=1 both times, NUM_ITER unchanged.
//  ABORT in same cycle as 2nd iter_done: core_abort_o 1 pulse, ITER_CNT=1, ABORTED=1, DONE=0.
//  IRQ_EN=1, finish job -> irq_o=1; write STATUS=0x2 -> irq_o=0 next cycle.
//  Read 0x20 -> error=1, rdata=0; read 0x14 after 10-cycle job -> 10 with PERF_EN, 0 without.

Source files
------------

// File: rtl/ising_logic_pkg.sv
// Shared definitions for the Ising core control front end: register offsets,
// CTRL/STATUS bit positions, the job sequencer states and the address decoder.
package ising_logic_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_NUM_ITER = 8'h08;
    localparam logic [7:0] REG_ITER_CNT = 8'h0C;
    localparam logic [7:0] REG_BEST_E   = 8'h10;
    localparam logic [7:0] REG_PERF_CYC = 8'h14;

    localparam int CTRL_START_BIT     = 0;
    localparam int CTRL_ABORT_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT    = 2;
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_ABORTED_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } ctrl_state_e;

    // One-hot register select; all-zero means the address is unmapped.
    typedef struct packed {
        logic ctrl;
        logic status;
        logic num_iter;
        logic iter_cnt;
        logic best_e;
        logic perf_cyc;
    } reg_sel_t;

    function automatic reg_sel_t decode_addr(input logic [31:0] addr);
        reg_sel_t sel;
        sel = '0;
        case (addr)
            32'(REG_CTRL):     sel.ctrl     = 1'b1;
            32'(REG_STATUS):   sel.status   = 1'b1;
            32'(REG_NUM_ITER): sel.num_iter = 1'b1;
            32'(REG_ITER_CNT): sel.iter_cnt = 1'b1;
            32'(REG_BEST_E):   sel.best_e   = 1'b1;
            32'(REG_PERF_CYC): sel.perf_cyc = 1'b1;
            default:           sel          = '0;
        endcase
        return sel;
    endfunction

    function automatic logic is_mapped(input reg_sel_t sel);
        return |sel;
    endfunction

    function automatic logic is_read_only(input reg_sel_t sel);
        return sel.iter_cnt | sel.best_e | sel.perf_cyc;
    endfunction

endpackage

// File: rtl/ising_energy_min_tracker.sv
// Running signed minimum of the energies reported by the core; clears to the
// largest positive value so the first reported energy always wins.
module ising_energy_min_tracker #(
    parameter int EnergyWidth = 24
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_update,
    input  logic signed [EnergyWidth-1:0] i_energy,
    output logic signed [EnergyWidth-1:0] o_best
);

    localparam logic signed [EnergyWidth-1:0] MaxPos = {1'b0, {(EnergyWidth-1){1'b1}}};

    logic signed [EnergyWidth-1:0] r_best;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_best <= MaxPos;
        end else if (i_update && (i_energy < r_best)) begin
            r_best <= i_energy;
        end
    end

    assign o_best = r_best;

endmodule

// File: rtl/ising_core_ctrl_regs.sv
// Register front end and job sequencer for one Ising core (load, then N iterations).
// Optional cycle counter at 0x14 is built when ISING_CORE_CTRL_PERF_EN is defined.
module ising_core_ctrl_regs #(
    parameter int AddrWidth   = 8,
    parameter int DataWidth   = 32,
    parameter int IterWidth   = 16,
    parameter int EnergyWidth = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          reg_valid_i,
    input  logic                          reg_write_i,
    input  logic [AddrWidth-1:0]          reg_addr_i,
    input  logic [DataWidth-1:0]          reg_wdata_i,
    input  logic [DataWidth/8-1:0]        reg_wstrb_i,
    output logic                          reg_ready_o,
    output logic [DataWidth-1:0]          reg_rdata_o,
    output logic                          reg_error_o,
    output logic                          core_load_o,
    input  logic                          core_load_ack_i,
    output logic                          core_iter_start_o,
    input  logic                          core_iter_done_i,
    input  logic signed [EnergyWidth-1:0] core_energy_i,
    output logic                          core_abort_o,
    output logic                          irq_o
);

    import ising_logic_pkg::*;

    localparam int StrbWidth = DataWidth / 8;

    ctrl_state_e            r_state;
    logic                   r_irq_en;
    logic                   r_done;
    logic                   r_aborted;
    logic [IterWidth-1:0]   r_num_iter;
    logic [IterWidth-1:0]   r_iter_cnt;
    logic                   r_core_load;
    logic                   r_iter_start;
    logic                   r_core_abort;
    logic                   r_irq;

    reg_sel_t                      w_sel;
    logic                          w_busy;
    logic                          w_ctrl_act;
    logic                          w_err;
    logic                          w_wr_ok;
    logic                          w_start;
    logic                          w_abort;
    logic                          w_best_update;
    logic [DataWidth-1:0]          w_wmask;
    logic [IterWidth-1:0]          w_num_iter_next;
    logic [IterWidth-1:0]          w_iter_cnt_inc;
    logic [DataWidth-1:0]          w_rdata;
    logic [31:0]                   w_perf_rdata;
    logic signed [EnergyWidth-1:0] w_best;
    logic                          w_unused_bits;

    assign w_sel      = decode_addr(32'(reg_addr_i));
    assign w_busy     = (r_state != ST_IDLE);
    assign w_ctrl_act = w_sel.ctrl & reg_wstrb_i[0];

    // A rejected write has no side effect at all, including the IRQ_EN bit of CTRL.
    assign w_err = reg_valid_i &
                   (~is_mapped(w_sel) |
                    (reg_write_i & (is_read_only(w_sel) |
                                    (w_busy & (w_sel.num_iter |
                                               (w_ctrl_act & reg_wdata_i[CTRL_START_BIT]))))));

    assign w_wr_ok = reg_valid_i & reg_write_i & ~w_err;
    assign w_start = w_wr_ok & w_ctrl_act & reg_wdata_i[CTRL_START_BIT];
    assign w_abort = w_wr_ok & w_ctrl_act & reg_wdata_i[CTRL_ABORT_BIT] & w_busy;

    assign w_best_update  = (r_state == ST_WAIT) & core_iter_done_i & ~w_abort;
    assign w_iter_cnt_inc = (r_iter_cnt == '1) ? r_iter_cnt : r_iter_cnt + IterWidth'(1);

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < StrbWidth; b++) begin
            w_wmask[8*b +: 8] = {8{reg_wstrb_i[b]}};
        end
        w_num_iter_next = (r_num_iter & ~w_wmask[IterWidth-1:0]) |
                          (reg_wdata_i[IterWidth-1:0] & w_wmask[IterWidth-1:0]);
    end

    assign w_unused_bits = ^{reg_wdata_i[DataWidth-1:IterWidth], w_wmask[DataWidth-1:IterWidth]};

    // NOTE: default assignment first so no path leaves w_rdata unassigned (no latch).
    always_comb begin
        w_rdata = '0;
        if (reg_valid_i && !reg_write_i) begin
            if (w_sel.ctrl) begin
                w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            if (w_sel.status) begin
                w_rdata[STATUS_BUSY_BIT]    = w_busy;
                w_rdata[STATUS_DONE_BIT]    = r_done;
                w_rdata[STATUS_ABORTED_BIT] = r_aborted;
            end
            if (w_sel.num_iter) begin
                w_rdata[IterWidth-1:0] = r_num_iter;
            end
            if (w_sel.iter_cnt) begin
                w_rdata[IterWidth-1:0] = r_iter_cnt;
            end
            if (w_sel.best_e) begin
                w_rdata = {{(DataWidth-EnergyWidth){w_best[EnergyWidth-1]}}, w_best};
            end
            if (w_sel.perf_cyc) begin
                w_rdata = DataWidth'(w_perf_rdata);
            end
        end
    end

    ising_energy_min_tracker #(
        .EnergyWidth(EnergyWidth)
    ) u_min_tracker (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clear  (w_start),
        .i_update (w_best_update),
        .i_energy (core_energy_i),
        .o_best   (w_best)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_irq_en     <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_num_iter   <= '0;
            r_iter_cnt   <= '0;
            r_core_load  <= 1'b0;
            r_iter_start <= 1'b0;
            r_core_abort <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_core_abort <= 1'b0;
            r_iter_start <= 1'b0;
            r_irq        <= r_irq_en & (r_done | r_aborted);

            if (w_wr_ok && w_ctrl_act) begin
                r_irq_en <= reg_wdata_i[CTRL_IRQ_EN_BIT];
            end
            if (w_wr_ok && w_sel.num_iter) begin
                r_num_iter <= w_num_iter_next;
            end
            if (w_wr_ok && w_sel.status && reg_wstrb_i[0]) begin
                if (reg_wdata_i[STATUS_DONE_BIT])    r_done    <= 1'b0;
                if (reg_wdata_i[STATUS_ABORTED_BIT]) r_aborted <= 1'b0;
            end

            // Abort outranks a same-cycle load ack or iteration done.
            if (w_abort) begin
                r_state      <= ST_IDLE;
                r_core_load  <= 1'b0;
                r_core_abort <= 1'b1;
                r_aborted    <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_iter_cnt <= '0;
                            r_aborted  <= 1'b0;
                            if (r_num_iter == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_done      <= 1'b0;
                                r_core_load <= 1'b1;
                                r_state     <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (core_load_ack_i) begin
                            r_core_load  <= 1'b0;
                            r_iter_start <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_iter_done_i) begin
                            r_iter_cnt <= w_iter_cnt_inc;
                            if (w_iter_cnt_inc == r_num_iter) begin
                                r_state <= ST_FIN;
                            end else begin
                                r_iter_start <= 1'b1;
                                r_state      <= ST_ISSUE;
                            end
                        end
                    end
                    ST_FIN: begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ISING_CORE_CTRL_PERF_EN
    logic [31:0] r_perf_cyc;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_perf_cyc <= '0;
        end else if (w_busy && (r_perf_cyc != '1)) begin
            r_perf_cyc <= r_perf_cyc + 32'd1;
        end
    end

    assign w_perf_rdata = r_perf_cyc;
`else
    assign w_perf_rdata = '0;
`endif

    assign reg_ready_o       = reg_valid_i;
    assign reg_rdata_o       = w_rdata;
    assign reg_error_o       = w_err;
    assign core_load_o       = r_core_load;
    assign core_iter_start_o = r_iter_start;
    assign core_abort_o      = r_core_abort;
    assign irq_o             = r_irq;

endmodule

// File: tb/tb_ising_core_ctrl_regs.sv
// Self-checking bench for ising_core_ctrl_regs: register table, then job,
// zero-iteration, busy-error, abort race, interrupt and cycle-counter sequences.
module tb_ising_core_ctrl_regs;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               reg_valid_i;
    logic               reg_write_i;
    logic [7:0]         reg_addr_i;
    logic [31:0]        reg_wdata_i;
    logic [3:0]         reg_wstrb_i;
    logic               reg_ready_o;
    logic [31:0]        reg_rdata_o;
    logic               reg_error_o;
    logic               core_load_o;
    logic               core_load_ack_i;
    logic               core_iter_start_o;
    logic               core_iter_done_i;
    logic signed [23:0] core_energy_i;
    logic               core_abort_o;
    logic               irq_o;

    // Core model outputs (m_*) and hand-driven outputs (t_*).
    logic               model_en = 1'b0;
    logic               m_ack = 1'b0, m_done = 1'b0;
    logic signed [23:0] m_energy = '0;
    logic               t_ack = 1'b0, t_done = 1'b0;
    logic signed [23:0] t_energy = '0;
    int                 m_delay = 4;
    int                 m_idx = 0;
    int                 e_tab[4];
    int                 n_start = 0, n_load = 0, n_abort = 0;

    int n_total = 0;
    int n_bad   = 0;

    assign core_load_ack_i  = model_en ? m_ack    : t_ack;
    assign core_iter_done_i = model_en ? m_done   : t_done;
    assign core_energy_i    = model_en ? m_energy : t_energy;

    ising_core_ctrl_regs dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .reg_valid_i       (reg_valid_i),
        .reg_write_i       (reg_write_i),
        .reg_addr_i        (reg_addr_i),
        .reg_wdata_i       (reg_wdata_i),
        .reg_wstrb_i       (reg_wstrb_i),
        .reg_ready_o       (reg_ready_o),
        .reg_rdata_o       (reg_rdata_o),
        .reg_error_o       (reg_error_o),
        .core_load_o       (core_load_o),
        .core_load_ack_i   (core_load_ack_i),
        .core_iter_start_o (core_iter_start_o),
        .core_iter_done_i  (core_iter_done_i),
        .core_energy_i     (core_energy_i),
        .core_abort_o      (core_abort_o),
        .irq_o             (irq_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Core model: acks a load request at once, reports done m_delay cycles after each start.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            if (core_iter_start_o) n_start++;
            if (core_load_o)       n_load++;
            if (core_abort_o)      n_abort++;
            m_done = 1'b0;
            if (model_en) begin
                m_ack = core_load_o;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_done   = 1'b1;
                        m_energy = 24'(e_tab[m_idx]);
                        m_idx++;
                    end
                end
                if (core_iter_start_o) cd = m_delay;
            end else begin
                m_ack = 1'b0;
                cd    = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic err, output logic rdy);
        @(negedge clk);
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
        #1;
        rdata = reg_rdata_o;
        err   = reg_error_o;
        rdy   = reg_ready_o;
        @(posedge clk);
        #1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
    endtask

    task automatic wr_chk(input string name, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic exp_err);
        logic [31:0] rd;
        logic        er, rdy;
        bus(1'b1, addr, wdata, 4'hF, rd, er, rdy);
        check(name, 32'(er), 32'(exp_err));
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er, rdy;
        bus(1'b0, addr, '0, 4'hF, rd, er, rdy);
        check(name, rd, exp);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        logic [31:0] rd;
        logic        er, rdy;
        rd = 32'h1;
        for (int k = 0; k < max_cyc; k++) begin
            bus(1'b0, 8'h04, '0, 4'hF, rd, er, rdy);
            if (!rd[0]) break;
        end
        check({name, " idle"}, 32'(rd[0]), 32'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic chk_rd,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        vec_t        vt[$];
        logic [31:0] rd;
        logic        er, rdy;
        int          s0, l0, a0;

        vt.push_back(mk(0, 8'h00, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(0, 8'h04, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(0, 8'h08, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(0, 8'h0C, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(0, 8'h10, 0, 4'hF, 1, 32'h007F_FFFF, 0));
        vt.push_back(mk(0, 8'h14, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(0, 8'h20, 0, 4'hF, 1, 32'h0000_0000, 1));
        vt.push_back(mk(0, 8'h18, 0, 4'hF, 1, 32'h0000_0000, 1));
        vt.push_back(mk(1, 8'h08, 32'hABCD_1234, 4'b0001, 0, 0, 0));
        vt.push_back(mk(0, 8'h08, 0, 4'hF, 1, 32'h0000_0034, 0));
        vt.push_back(mk(1, 8'h08, 32'hFFFF_5600, 4'b0010, 0, 0, 0));
        vt.push_back(mk(0, 8'h08, 0, 4'hF, 1, 32'h0000_5634, 0));
        vt.push_back(mk(1, 8'h08, 32'hFFFF_FFFF, 4'b1100, 0, 0, 0));
        vt.push_back(mk(0, 8'h08, 0, 4'hF, 1, 32'h0000_5634, 0));
        vt.push_back(mk(1, 8'h0C, 32'h1, 4'hF, 0, 0, 1));
        vt.push_back(mk(1, 8'h10, 32'h1, 4'hF, 0, 0, 1));
        vt.push_back(mk(1, 8'h14, 32'h1, 4'hF, 0, 0, 1));
        vt.push_back(mk(1, 8'h03, 32'h1, 4'hF, 0, 0, 1));
        vt.push_back(mk(0, 8'h02, 0, 4'hF, 1, 32'h0000_0000, 1));
        vt.push_back(mk(0, 8'h0C, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(1, 8'h00, 32'h4, 4'b0000, 0, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(1, 8'h00, 32'h4, 4'b0001, 0, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 4'hF, 1, 32'h0000_0004, 0));
        vt.push_back(mk(1, 8'h00, 32'h6, 4'b0001, 0, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 4'hF, 1, 32'h0000_0004, 0));
        vt.push_back(mk(0, 8'h04, 0, 4'hF, 1, 32'h0000_0000, 0));
        vt.push_back(mk(1, 8'h00, 32'h0, 4'b0001, 0, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 4'hF, 1, 32'h0000_0000, 0));

        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        check("reset core_load_o",       32'(core_load_o),       32'h0);
        check("reset core_iter_start_o", 32'(core_iter_start_o), 32'h0);
        check("reset core_abort_o",      32'(core_abort_o),      32'h0);
        check("reset irq_o",             32'(irq_o),             32'h0);
        check("reset reg_ready_o",       32'(reg_ready_o),       32'h0);

        foreach (vt[i]) begin
            bus(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, rdy);
            if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d error", i), 32'(er), 32'(vt[i].exp_err));
            if (i == 0) check("vec0 ready", 32'(rdy), 32'h1);
        end

        // Three-iteration job with busy-time writes rejected.
        e_tab[0] = -5; e_tab[1] = -9; e_tab[2] = -7;
        m_idx = 0; m_delay = 4; model_en = 1'b1;
        s0 = n_start;
        wr_chk("A num_iter write", 8'h08, 32'h3, 1'b0);
        wr_chk("A start",          8'h00, 32'h1, 1'b0);
        wr_chk("A busy num_iter",  8'h08, 32'h8, 1'b1);
        wr_chk("A busy start",     8'h00, 32'h1, 1'b1);
        rd_chk("A num_iter kept",  8'h08, 32'h3);
        wait_idle("A", 200);
        rd_chk("A iter_cnt", 8'h0C, 32'h3);
        rd_chk("A best_e",   8'h10, 32'hFFFF_FFF7);
        rd_chk("A status",   8'h04, 32'h2);
        check("A start pulses", 32'(n_start - s0), 32'd3);
        check("A irq off",      32'(irq_o),        32'h0);

        // Zero iterations: DONE next cycle, no core activity.
        repeat (3) @(posedge clk);
        wr_chk("B clear done", 8'h04, 32'h2, 1'b0);
        rd_chk("B status cleared", 8'h04, 32'h0);
        l0 = n_load;
        s0 = n_start;
        wr_chk("B num_iter 0", 8'h08, 32'h0, 1'b0);
        wr_chk("B start",      8'h00, 32'h1, 1'b0);
        rd_chk("B status done", 8'h04, 32'h2);
        repeat (3) @(posedge clk);
        check("B no load",  32'(n_load - l0),  32'd0);
        check("B no start", 32'(n_start - s0), 32'd0);

        // Abort in the same cycle as the second iteration done.
        model_en = 1'b0;
        repeat (2) @(posedge clk);
        wr_chk("D clear done", 8'h04, 32'h2, 1'b0);
        wr_chk("D num_iter",   8'h08, 32'h3, 1'b0);
        a0 = n_abort;
        wr_chk("D start",      8'h00, 32'h1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (core_load_o) break;
        end
        check("D load seen", 32'(core_load_o), 32'h1);
        t_ack = 1'b1;
        @(negedge clk);
        t_ack = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (core_iter_start_o) break;
            @(negedge clk);
        end
        check("D start1 seen", 32'(core_iter_start_o), 32'h1);
        repeat (2) @(negedge clk);
        t_done = 1'b1; t_energy = 24'(-4);
        @(negedge clk);
        t_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (core_iter_start_o) break;
            @(negedge clk);
        end
        check("D start2 seen", 32'(core_iter_start_o), 32'h1);
        @(negedge clk);
        t_done      = 1'b1;
        t_energy    = 24'(-20);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 8'h00;
        reg_wdata_i = 32'h2;
        reg_wstrb_i = 4'b0001;
        #1;
        check("D abort error", 32'(reg_error_o), 32'h0);
        @(posedge clk);
        #1;
        t_done      = 1'b0;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        @(negedge clk);
        check("D abort pulse high", 32'(core_abort_o), 32'h1);
        @(negedge clk);
        check("D abort pulse low",  32'(core_abort_o), 32'h0);
        check("D no start after",   32'(core_iter_start_o), 32'h0);
        rd_chk("D iter_cnt", 8'h0C, 32'h1);
        rd_chk("D status",   8'h04, 32'h4);
        rd_chk("D best_e",   8'h10, 32'hFFFF_FFFC);
        check("D abort count", 32'(n_abort - a0), 32'd1);

        // Interrupt on completion, cleared by W1C of DONE.
        wr_chk("E clear aborted", 8'h04, 32'h4, 1'b0);
        check("E irq before", 32'(irq_o), 32'h0);
        e_tab[0] = 100;
        m_idx = 0; m_delay = 2; model_en = 1'b1;
        wr_chk("E num_iter", 8'h08, 32'h1, 1'b0);
        wr_chk("E start",    8'h00, 32'h5, 1'b0);
        wait_idle("E", 100);
        repeat (2) begin @(posedge clk); #1; end
        check("E irq set", 32'(irq_o), 32'h1);
        wr_chk("E w1c done", 8'h04, 32'h2, 1'b0);
        @(posedge clk); #1;
        check("E irq cleared", 32'(irq_o), 32'h0);
        rd_chk("E best_e", 8'h10, 32'h0000_0064);

        // Ten busy cycles: 1 LOAD + 1 ISSUE + 7 WAIT + 1 FIN.
        wr_chk("F ctrl off", 8'h00, 32'h0, 1'b0);
        m_idx = 0; m_delay = 7;
        wr_chk("F num_iter", 8'h08, 32'h1, 1'b0);
        wr_chk("F start",    8'h00, 32'h1, 1'b0);
        wait_idle("F", 100);
`ifdef ISING_CORE_CTRL_PERF_EN
        rd_chk("F perf_cyc", 8'h14, 32'd10);
`else
        rd_chk("F perf_cyc", 8'h14, 32'd0);
`endif
        bus(1'b0, 8'h14, '0, 4'hF, rd, er, rdy);
        check("F perf error", 32'(er), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
